ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
- PS/2 device-to-host receiver feeding the PS/2 APB slave; the slave consumes `scan_code`, `ready` and `overflow` and drives `nextdata_n`.
- Oversamples raw `ps2_clk`/`ps2_data` on the system clock and deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop).
- Stores valid bytes in a small FIFO popped by an active-low strobe.
- Rejects bad frames and resynchronises after bus stalls.

Parameters:
- DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 entries (8).
- TIMEOUT, 16'd50000, clock cycles without a ps2_clk falling edge before a partial frame is discarded.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock, asynchronous to clock.
- ps2_data  input  1  raw PS/2 data, asynchronous to clock.
- nextdata_n  input  1  active-low pop request, sampled every cycle.
- scan_code  output  8  FIFO head byte; valid only while ready=1.
- ready  output  1  FIFO non-empty.
- overflow  output  1  sticky: a valid frame was dropped because the FIFO was full.
- frame_err  output  1  one-cycle pulse on a rejected frame (start/parity/stop error or timeout).

Behaviour:
- **Reset values:**
  - ready=0, overflow=0, frame_err=0; scan_code don't-care.
  - FIFO pointers cleared, bit counter=0, timeout counter=0.
  - Synchroniser flops = 1 (idle bus).
- **Synchroniser:**
  - 2-flop sync on both ps2_clk and ps2_data, plus one history flop on clk.
  - fall = (hist==1 && sync==0).
  - Data is sampled from synced ps2_data in the same cycle fall is true.
- **Deframer:** bit counter 0..10, advances on each fall.
  - Count 0: sampled bit must be 0; if 1, discard and stay at count 0, no frame_err (line-noise tolerance).
  - Counts 1..8: shift data into byte LSB-first.
  - Count 9: capture parity bit.
  - Count 10: frame check. Valid iff stop==1 and XOR(data, parity)==1. Counter returns to 0 either way.
    - Valid frame → FIFO push in that same cycle.
    - Invalid frame → frame_err=1 next cycle, no push.
- **Timeout:**
  - Counter increments while bit counter≠0; cleared on every fall and whenever bit counter==0.
  - Reaching TIMEOUT → bit counter=0, timeout counter cleared, frame_err pulses.
- **FIFO:** wptr/rptr each DEPTH_LOG2+1 bits; count = wptr−rptr, modulo wrap.
  - scan_code = mem[rptr[DEPTH_LOG2-1:0]], combinational from registered storage.
  - ready = (count≠0).
  - Push latency: ready/scan_code reflect a new byte the cycle after the stop-bit fall.
  - Pop: any cycle with nextdata_n==0 and ready==1 → rptr+1. Low for N cycles pops up to N entries; the APB slave pulses it exactly one cycle per read.
  - Pop when empty: ignored.
  - Push when count==DEPTH with no pop in the same cycle: byte dropped, overflow←1.
  - Push and pop in the same cycle when full: both performed, no overflow.
  - Push and pop in the same cycle when empty: push only; pop ignored.
  - overflow clears on the next successful pop, or on reset.
- **Reset mid-frame:** partial frame discarded, FIFO emptied; the next frame is decoded normally from its start bit.

Test Plan:
- **Single valid frame.** Send 0x1C (bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at a 12.5 kHz ps2_clk.
  - Required: ready=1 one cycle after the stop-bit fall, scan_code=0x1C.
  - Then a 1-cycle nextdata_n=0 → ready=0 next cycle.
- **Ordering.** Send 0xF0 (parity 1), then 0x1C.
  - Required: pops return 0xF0 then 0x1C; ready drops after the second pop; overflow=0, frame_err never pulses.
- **Parity error.** Send 0x1C with parity=1.
  - Required: frame_err pulses once, ready stays 0.
  - A following valid 0x32 frame yields scan_code=0x32.
- **Overflow.** Send 9 frames 0x01..0x09 with no pops.
  - Required: overflow=1 after the 9th frame.
  - Pops return 0x01..0x08; overflow=0 after the first pop.
- **Full push+pop.** With the FIFO holding 8 entries, drive nextdata_n=0 in the exact stop-bit fall cycle of 0x0A.
  - Required: count stays 8, overflow stays 0, 0x0A is the last entry popped.
- **Timeout / reset mid-frame.**
  - Stop ps2_clk after 4 bits and wait TIMEOUT cycles → frame_err pulses; a subsequent full 0x1C frame decodes correctly.
  - Repeat with reset asserted mid-frame instead → FIFO empty, next 0x1C decodes.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx_fifo
// Purpose  : PS/2 device-to-host receiver. It oversamples the bus, deframes
//            11-bit frames and queues valid bytes in a small FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo #(
    parameter int          DEPTH_LOG2 = 3,
    parameter logic [15:0] TIMEOUT    = 16'd50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] scan_code,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int               DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

    logic clk_s1, clk_s2, clk_hist;
    logic data_s1, data_s2;
    logic fall;

    logic [3:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        parity;
    logic [15:0] tcnt;
    logic        push;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2:0]   wptr, rptr, count;
    logic                  full, pop, do_write;

    // Synchronisers idle high so reset never manufactures a falling edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_hist <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_hist <= clk_s2;
            data_s1  <= ps2_data;
            data_s2  <= data_s1;
        end
    end

    assign fall = clk_hist & ~clk_s2;

    // Stop bit must be 1 and the nine data+parity bits must have odd weight.
    assign push = fall && (bit_cnt == 4'd10) && data_s2 && ((^shreg) ^ parity);

    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt   <= 4'd0;
            shreg     <= 8'd0;
            parity    <= 1'b0;
            tcnt      <= 16'd0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (fall) begin
                tcnt <= 16'd0;
                case (bit_cnt)
                    4'd0: begin
                        if (!data_s2)
                            bit_cnt <= 4'd1;
                    end
                    4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
                        shreg   <= {data_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    4'd9: begin
                        parity  <= data_s2;
                        bit_cnt <= 4'd10;
                    end
                    4'd10: begin
                        bit_cnt <= 4'd0;
                        if (!push)
                            frame_err <= 1'b1;
                    end
                    default: bit_cnt <= 4'd0;
                endcase
            end else if (bit_cnt == 4'd0) begin
                tcnt <= 16'd0;
            end else if (tcnt == TIMEOUT - 16'd1) begin
                bit_cnt   <= 4'd0;
                tcnt      <= 16'd0;
                frame_err <= 1'b1;
            end else begin
                tcnt <= tcnt + 16'd1;
            end
        end
    end

    assign count     = wptr - rptr;
    assign ready     = (count != '0);
    assign full      = (count == COUNT_FULL);
    assign pop       = ~nextdata_n & ready;
    // A simultaneous pop frees the slot the push needs, so full+pop still writes.
    assign do_write  = push & (~full | pop);
    assign scan_code = mem[rptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_write)
                wptr <= wptr + 1'b1;
            if (pop) begin
                rptr     <= rptr + 1'b1;
                overflow <= 1'b0;
            end else if (push && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_write)
            mem[wptr[DEPTH_LOG2-1:0]] <= shreg;
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_rx_fifo
// Purpose  : Self-checking bench for ps2_rx_fifo against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_fifo;

    localparam int          HALF    = 10;
    localparam logic [15:0] TIMEOUT = 16'd1000;

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic [7:0] scan_code;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    int checks   = 0;
    int errors   = 0;
    int err_seen = 0;
    int exp_err  = 0;

    logic [7:0] q[$];
    logic       ovf = 1'b0;

    ps2_rx_fifo #(.DEPTH_LOG2(3), .TIMEOUT(TIMEOUT)) dut (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .scan_code  (scan_code),
        .ready      (ready),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 clock = ~clock;

    always @(negedge clock)
        if (frame_err === 1'b1)
            err_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_cycles(HALF);
        ps2_clk = 1'b0;
        wait_cycles(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit pop_at_stop);
        logic [10:0] bits;
        bit valid, lat, popped;
        bits[0]    = 1'b0;
        bits[8:1]  = b;
        bits[9]    = (~^b) ^ bad_par;
        bits[10]   = ~bad_stop;
        valid      = !bad_par && !bad_stop;
        lat        = valid && (q.size() == 0) && !pop_at_stop;
        popped     = 1'b0;
        for (int i = 0; i < 10; i++)
            ps2_bit(bits[i]);
        ps2_data = bits[10];
        wait_cycles(HALF);
        ps2_clk = 1'b0;
        wait_cycles(2);
        if (lat)
            check("ready_before_push", ready, 0);
        if (pop_at_stop && q.size() > 0) begin
            check("head_at_stop", scan_code, q[0]);
            nextdata_n = 1'b0;
            popped     = 1'b1;
        end
        wait_cycles(1);
        nextdata_n = 1'b1;
        if (popped) begin
            void'(q.pop_front());
            ovf = 1'b0;
        end
        if (valid) begin
            if (q.size() < 8) q.push_back(b);
            else              ovf = 1'b1;
        end else begin
            exp_err++;
        end
        if (lat) begin
            check("ready_after_push", ready, 1);
            check("scan_code_new", scan_code, b);
        end
        wait_cycles(HALF - 3);
        ps2_clk = 1'b1;
        wait_cycles(HALF);
        check("overflow", overflow, ovf);
        check("ready", ready, q.size() != 0);
        check("frame_err_count", err_seen, exp_err);
    endtask

    task automatic pop_one();
        check("ready_pre_pop", ready, q.size() != 0);
        if (q.size() > 0)
            check("scan_code_pop", scan_code, q[0]);
        nextdata_n = 1'b0;
        wait_cycles(1);
        nextdata_n = 1'b1;
        if (q.size() > 0) begin
            void'(q.pop_front());
            ovf = 1'b0;
        end
        check("ready_post_pop", ready, q.size() != 0);
        check("overflow_post_pop", overflow, ovf);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
        q.delete();
        ovf = 1'b0;
        wait_cycles(1);
        check("rst_ready", ready, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_err", frame_err, 0);
    endtask

    initial begin
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        nextdata_n = 1'b1;
        reset      = 1'b1;
        wait_cycles(3);
        do_reset();

        // Single frame, then ordering.
        send_frame(8'h1C, 0, 0, 0);
        pop_one();
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h1C, 0, 0, 0);
        pop_one();
        pop_one();
        pop_one();

        // Parity and stop errors, line noise before a start bit.
        send_frame(8'h1C, 1, 0, 0);
        send_frame(8'h32, 0, 0, 0);
        pop_one();
        send_frame(8'hA5, 0, 1, 0);
        ps2_bit(1'b1);
        send_frame(8'h5A, 0, 0, 0);
        pop_one();

        // Overflow: nine frames into an eight-entry FIFO.
        for (int i = 1; i <= 9; i++)
            send_frame(8'(i), 0, 0, 0);
        for (int i = 0; i < 8; i++)
            pop_one();

        // Full FIFO with a pop in the stop-bit fall cycle.
        for (int i = 2; i <= 9; i++)
            send_frame(8'(i), 0, 0, 0);
        send_frame(8'h0A, 0, 0, 1);
        for (int i = 0; i < 8; i++)
            pop_one();

        // Stall mid-frame until the timeout discards it.
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        wait_cycles(int'(TIMEOUT) + 20);
        exp_err++;
        check("timeout_err", err_seen, exp_err);
        send_frame(8'h1C, 0, 0, 0);
        pop_one();

        // Reset mid-frame with a byte queued.
        send_frame(8'h55, 0, 0, 0);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        do_reset();
        send_frame(8'h1C, 0, 0, 0);
        pop_one();

        // Randomised traffic.
        for (int n = 0; n < 40; n++) begin
            int kind;
            int npop;
            logic [7:0] b;
            b    = 8'($urandom);
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0)
                ps2_bit(1'b1);
            send_frame(b, kind == 0, kind == 1, $urandom_range(0, 5) == 0);
            npop = $urandom_range(0, 2);
            for (int k = 0; k < npop; k++)
                pop_one();
        end
        while (q.size() > 0)
            pop_one();
        pop_one();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
